// File: rtl/regfile_read_port.sv
// Pipelined single read port for the register file: one-cycle read latency, valid/ready on both
// sides. Define READ_BYPASS_EN to forward same-cycle writes into new and stalled responses.
module regfile_read_port #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREGS*WIDTH-1:0]   regs_flat,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     req_valid,
    input  logic [$clog2(NREGS)-1:0] req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [$clog2(NREGS)-1:0] rsp_addr,
    input  logic                     rsp_ready
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;

    logic             accept;
    logic             req_in_range;
    logic             req_is_zero;
    logic [WIDTH-1:0] reg_word;
    logic [WIDTH-1:0] sel_data;

    assign req_ready = (state_q == StEmpty) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == StFull);
    assign rsp_data  = data_q;
    assign rsp_addr  = addr_q;

    assign req_is_zero = (req_addr == AW'(ZERO_REG));

    // Explicit decode so addresses beyond NREGS fall through to zero.
    always_comb begin
        reg_word     = '0;
        req_in_range = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (req_addr == AW'(i)) begin
                reg_word     = regs_flat[i*WIDTH +: WIDTH];
                req_in_range = 1'b1;
            end
        end
    end

`ifdef READ_BYPASS_EN
    logic req_hit;
    logic hold_hit;

    assign req_hit  = wr_en && (wr_addr == req_addr) && !req_is_zero;
    assign hold_hit = wr_en && (wr_addr == addr_q) && (addr_q != AW'(ZERO_REG));

    always_comb begin
        sel_data = '0;
        if (req_in_range && !req_is_zero) begin
            sel_data = req_hit ? wr_data : reg_word;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        sel_data = '0;
        if (req_in_range && !req_is_zero) begin
            sel_data = reg_word;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (accept) begin
            state_d = StFull;
            data_d  = sel_data;
            addr_d  = req_addr;
        end else if ((state_q == StFull) && rsp_ready) begin
            state_d = StEmpty;
        end
`ifdef READ_BYPASS_EN
        // A stalled response tracks writes to its register so it is never stale when consumed.
        else if ((state_q == StFull) && hold_hit) begin
            data_d = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Scoreboard bench for regfile_read_port: stimulus pushes expected responses, a negedge monitor
// pops and compares them at every response handshake.
module tb_regfile_read_port;

    logic          clk = 1'b0;
    logic          reset;
    logic [2047:0] regs_flat;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          req_valid;
    logic [4:0]    req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [63:0]   rsp_data;
    logic [4:0]    rsp_addr;
    logic          rsp_ready;

    logic [63:0] regs [32];
    logic [68:0] exp_q [$];
    int          tests  = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 32; i++) regs_flat[i*64 +: 64] = regs[i];
    end

    regfile_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .regs_flat (regs_flat),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_ready (rsp_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [63:0] exp_data);
        req_valid = 1'b1;
        req_addr  = a;
        exp_q.push_back({a, exp_data});
    endtask

    // Monitor: every consumed response must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_addr), 64'hDEAD);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                check("rsp_addr", 64'(rsp_addr), 64'(e[68:64]));
                check("rsp_data", rsp_data, e[63:0]);
            end
        end
    end

    initial begin
        logic [63:0] old5;
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        regs[3]  = 64'hA5;
        regs[7]  = 64'h11;
        regs[31] = 64'hFFFF;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

        step(); step();
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_rsp_addr", 64'(rsp_addr), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);

        // Basic read, latency one.
        reset = 1'b1;
        issue(5'd3, 64'hA5);
        step();
        req_valid = 1'b0;
        check("lat1_rsp_valid", 64'(rsp_valid), 64'd1);
        step();

        // Zero register, even with a same-cycle write to it.
        issue(5'd31, 64'd0);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h7;
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        step();

        // Back-to-back reads at full rate.
        for (int i = 1; i <= 3; i++) begin
            issue(5'(i), regs[i]);
            check("b2b_req_ready", 64'(req_ready), 64'd1);
            step();
        end
        req_valid = 1'b0;
        step();

        // Stall with a write to the held register.
        old5 = regs[5];
`ifdef READ_BYPASS_EN
        issue(5'd5, 64'h55);
`else
        issue(5'd5, old5);
`endif
        step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("stall_data_first", rsp_data, old5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h55;
        step();
        wr_en = 1'b0; regs[5] = 64'h55;
        check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        check("stall_req_ready", 64'(req_ready), 64'd0);
        check("stall_rsp_addr", 64'(rsp_addr), 64'd5);
`ifdef READ_BYPASS_EN
        check("stall_data_bypass", rsp_data, 64'h55);
`else
        check("stall_data_held", rsp_data, old5);
`endif
        step(); step();
        check("stall_still_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        check("drained_empty", 64'(rsp_valid), 64'd0);

        // Same-cycle write to the requested register.
`ifdef READ_BYPASS_EN
        issue(5'd7, 64'h99);
`else
        issue(5'd7, 64'h11);
`endif
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h99;
        step();
        wr_en = 1'b0; req_valid = 1'b0; regs[7] = 64'h99;
        step();

        // Reset while a stalled response is held discards it.
        req_valid = 1'b1; req_addr = 5'd10;
        step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        step();
        check("pre_reset_full", 64'(rsp_valid), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_full_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_full_rsp_data", rsp_data, 64'd0);
        check("rst_full_req_ready", 64'(req_ready), 64'd1);
        issue(5'd12, regs[12]);
        step();
        req_valid = 1'b0; rsp_ready = 1'b1;
        step(); step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
